// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - state encodings and datapath mux codes for the multi-cycle sequencer
package multicycle_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   localparam logic [1:0] PC_SRC_NEXT   = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JR     = 2'd2;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd3;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_MDR  = 2'd1;
   localparam logic [1:0] WB_SEL_LINK = 2'd2;

   // States that own the shared memory port and may therefore time out.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM);
   endfunction

   // Unknown decoder codes fall back to sequential flow.
   function automatic logic [1:0] clean_pc_select(input logic [1:0] sel);
      logic [1:0] res;
      case (sel)
         2'd1:    res = PC_SRC_BRANCH;
         2'd2:    res = PC_SRC_JR;
         2'd3:    res = PC_SRC_JUMP;
         default: res = PC_SRC_NEXT;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_timeout_timer.sv
// rtl/mem_timeout_timer.sv - counts consecutive unacknowledged memory cycles and flags expiry
module mem_timeout_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ack,
   output logic expired
);

   localparam int TW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

   logic [TW-1:0] count;

   // count holds the number of completed wait cycles; the current cycle is the LIMIT-th
   // when count == LIMIT-1, so expiry is raised combinationally in that cycle.
   always_ff @(posedge clk) begin
      if (reset || !active || ack) begin
         count <= '0;
      end else begin
         count <= count + TW'(1);
      end
   end

   always_comb begin
      expired = 1'b0;
      if ((LIMIT != 0) && active && !ack && (count == TW'(LIMIT - 1))) begin
         expired = 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB control FSM owning the shared memory port
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [1:0]       pc_select,
   input  logic             lw,
   input  logic             sw,
   input  logic             reg_write,
   input  logic             link,
   input  logic             branch_taken,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_load,
   output logic             mdr_load,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count,
   output logic             busy,
   output logic             err
);

   state_t state_q;
   state_t state_d;
   logic   retire;
   logic   timer_active;
   logic   timer_expired;

   assign state        = state_q;
   assign timer_active = is_mem_state(state_q);

   mem_timeout_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .active  (timer_active),
      .ack     (mem_ack),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
         end
      end
   end

   // Moore decodes of the registered state.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = WB_SEL_ALU;
      busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
      err          = (state_q == S_ERROR);
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = sw;
         end
         S_WB: begin
            reg_we = 1'b1;
            if (link) begin
               wb_sel = WB_SEL_LINK;
            end else if (lw) begin
               wb_sel = WB_SEL_MDR;
            end else begin
               wb_sel = WB_SEL_ALU;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      ir_load  = 1'b0;
      mdr_load = 1'b0;
      retire   = 1'b0;
      pc_src   = PC_SRC_NEXT;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end else if (timer_expired) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (lw || sw) begin
               state_d = S_MEM;
            end else if (link || reg_write) begin
               state_d = S_WB;
            end else begin
               retire = 1'b1;
               if ((clean_pc_select(pc_select) == PC_SRC_BRANCH) && !branch_taken) begin
                  pc_src = PC_SRC_NEXT;
               end else begin
                  pc_src = clean_pc_select(pc_select);
               end
            end
         end
         S_MEM: begin
            if (mem_ack && lw) begin
               mdr_load = 1'b1;
               state_d  = S_WB;
            end else if (mem_ack) begin
               retire = 1'b1;
               pc_src = PC_SRC_NEXT;
            end else if (timer_expired) begin
               state_d = S_ERROR;
            end
         end
         S_WB: begin
            retire = 1'b1;
            if (link) begin
               pc_src = PC_SRC_JUMP;
            end else if (clean_pc_select(pc_select) == PC_SRC_JR) begin
               pc_src = PC_SRC_JR;
            end else begin
               pc_src = PC_SRC_NEXT;
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // The instruction always finishes; run only decides whether another one starts.
      if (retire) begin
         state_d = run ? S_FETCH : S_IDLE;
      end
   end

   assign pc_write = retire;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [1:0]  pc_select;
   logic        lw;
   logic        sw;
   logic        reg_write;
   logic        link;
   logic        branch_taken;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        ir_load;
   logic        mdr_load;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state;
   logic [31:0] instr_count;
   logic        busy;
   logic        err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_count = 0;

   always #5 clk = ~clk;

   multicycle_sequencer #(
      .MEM_TIMEOUT (4),
      .CNT_W       (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .pc_select    (pc_select),
      .lw           (lw),
      .sw           (sw),
      .reg_write    (reg_write),
      .link         (link),
      .branch_taken (branch_taken),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_load      (ir_load),
      .mdr_load     (mdr_load),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .reg_we       (reg_we),
      .wb_sel       (wb_sel),
      .state        (state),
      .instr_count  (instr_count),
      .busy         (busy),
      .err          (err)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_decoder();
      pc_select    = 2'd0;
      lw           = 1'b0;
      sw           = 1'b0;
      reg_write    = 1'b0;
      link         = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      run   = 1'b0;
      mem_ack = 1'b1;
      clear_decoder();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (state !== 3'd0 || mem_req !== 1'b0 || pc_write !== 1'b0 || reg_we !== 1'b0 ||
          ir_load !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: state=%0d req=%b pcw=%b rwe=%b irl=%b busy=%b err=%b want all 0",
                  state, mem_req, pc_write, reg_we, ir_load, busy, err);
      end
      n_tests++;
      if (instr_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d want 0", instr_count);
      end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (state !== 3'd0 || ir_load !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: state=%0d ir_load=%b want 0/0", state, ir_load);
      end
   endtask

   task automatic test_alu();
      logic [2:0] es [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd0};
      logic       pw [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      clear_decoder();
      reg_write = 1'b1;
      mem_ack   = 1'b1;
      run       = 1'b1;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         if (k == 4) begin
            reg_write = 1'b0;
            run       = 1'b0;
         end
         @(negedge clk);
         n_tests++;
         if (state !== es[k] || pc_write !== pw[k]) begin
            n_fail++;
            $display("FAIL alu c%0d: state=%0d pc_write=%b want %0d/%b", k, state, pc_write, es[k], pw[k]);
         end
         if (k == 0) begin
            n_tests++;
            if (ir_load !== 1'b1 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
               n_fail++;
               $display("FAIL alu_fetch: ir_load=%b req=%b sel=%b want 1/1/0", ir_load, mem_req, mem_addr_sel);
            end
         end
         if (k == 3) begin
            n_tests++;
            if (reg_we !== 1'b1 || wb_sel !== 2'd0 || pc_src !== 2'd0 || instr_count !== exp_count) begin
               n_fail++;
               $display("FAIL alu_wb: reg_we=%b wb_sel=%0d pc_src=%0d cnt=%0d want 1/0/0/%0d",
                        reg_we, wb_sel, pc_src, instr_count, exp_count);
            end
            exp_count++;
         end
         if (k == 4) begin
            n_tests++;
            if (instr_count !== exp_count) begin
               n_fail++;
               $display("FAIL alu_count: got %0d want %0d", instr_count, exp_count);
            end
         end
         if (k == 6) exp_count++;
      end
      n_tests++;
      if (instr_count !== exp_count) begin
         n_fail++;
         $display("FAIL alu_count_end: got %0d want %0d", instr_count, exp_count);
      end
   endtask

   task automatic test_lw_wait();
      logic [2:0] es  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
      logic       ack [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       rn  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       sel [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       mdr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       pw  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      clear_decoder();
      lw        = 1'b1;
      reg_write = 1'b1;
      run       = 1'b1;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         mem_ack = ack[k];
         run     = rn[k];
         @(negedge clk);
         n_tests++;
         if (state !== es[k] || mem_addr_sel !== sel[k] || mem_we !== 1'b0 ||
             mdr_load !== mdr[k] || pc_write !== pw[k]) begin
            n_fail++;
            $display("FAIL lw c%0d: state=%0d sel=%b we=%b mdr=%b pcw=%b want %0d/%b/0/%b/%b",
                     k, state, mem_addr_sel, mem_we, mdr_load, pc_write, es[k], sel[k], mdr[k], pw[k]);
         end
         if (k == 6) begin
            n_tests++;
            if (wb_sel !== 2'd1 || reg_we !== 1'b1 || pc_src !== 2'd0) begin
               n_fail++;
               $display("FAIL lw_wb: wb_sel=%0d reg_we=%b pc_src=%0d want 1/1/0", wb_sel, reg_we, pc_src);
            end
            exp_count++;
         end
      end
      n_tests++;
      if (instr_count !== exp_count) begin
         n_fail++;
         $display("FAIL lw_count: got %0d want %0d", instr_count, exp_count);
      end
   endtask

   task automatic test_branch();
      logic [2:0] es [7] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd0};
      logic       bt [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       rn [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       pw [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [1:0] ps [7] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      clear_decoder();
      pc_select = 2'd1;
      mem_ack   = 1'b1;
      run       = 1'b1;
      for (int k = 0; k < 7; k++) begin
         next_cycle();
         branch_taken = bt[k];
         run          = rn[k];
         @(negedge clk);
         n_tests++;
         if (state !== es[k] || pc_write !== pw[k] || reg_we !== 1'b0 || (pw[k] && pc_src !== ps[k])) begin
            n_fail++;
            $display("FAIL branch c%0d: state=%0d pcw=%b reg_we=%b pc_src=%0d want %0d/%b/0/%0d",
                     k, state, pc_write, reg_we, pc_src, es[k], pw[k], ps[k]);
         end
         if (pw[k]) exp_count++;
      end
      n_tests++;
      if (instr_count !== exp_count) begin
         n_fail++;
         $display("FAIL branch_count: got %0d want %0d", instr_count, exp_count);
      end
   endtask

   task automatic test_jump();
      logic [2:0] es [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd0};
      clear_decoder();
      pc_select = 2'd3;
      link      = 1'b1;
      reg_write = 1'b1;
      mem_ack   = 1'b1;
      run       = 1'b1;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         if (k == 4) begin
            pc_select = 2'd2;
            link      = 1'b0;
            reg_write = 1'b0;
         end
         if (k == 6) run = 1'b0;
         @(negedge clk);
         n_tests++;
         if (state !== es[k]) begin
            n_fail++;
            $display("FAIL jump c%0d state: got %0d want %0d", k, state, es[k]);
         end
         if (k == 3) begin
            n_tests++;
            if (reg_we !== 1'b1 || wb_sel !== 2'd2 || pc_src !== 2'd3 || pc_write !== 1'b1) begin
               n_fail++;
               $display("FAIL jal_wb: reg_we=%b wb_sel=%0d pc_src=%0d pcw=%b want 1/2/3/1",
                        reg_we, wb_sel, pc_src, pc_write);
            end
            exp_count++;
         end
         if (k == 6) begin
            n_tests++;
            if (pc_src !== 2'd2 || pc_write !== 1'b1 || reg_we !== 1'b0) begin
               n_fail++;
               $display("FAIL jr_exec: pc_src=%0d pcw=%b reg_we=%b want 2/1/0", pc_src, pc_write, reg_we);
            end
            exp_count++;
         end
      end
      n_tests++;
      if (instr_count !== exp_count) begin
         n_fail++;
         $display("FAIL jump_count: got %0d want %0d", instr_count, exp_count);
      end
   endtask

   task automatic test_sw_run_drop();
      logic [2:0] es  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd0};
      logic       ack [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      clear_decoder();
      sw  = 1'b1;
      run = 1'b1;
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         mem_ack = ack[k];
         if (k == 3) run = 1'b0;
         @(negedge clk);
         n_tests++;
         if (state !== es[k]) begin
            n_fail++;
            $display("FAIL sw c%0d state: got %0d want %0d", k, state, es[k]);
         end
         if (k == 3 || k == 4) begin
            n_tests++;
            if (mem_we !== 1'b1 || mem_addr_sel !== 1'b1 || mem_req !== 1'b1 || pc_write !== (k == 4)) begin
               n_fail++;
               $display("FAIL sw_mem c%0d: we=%b sel=%b req=%b pcw=%b want 1/1/1/%0d",
                        k, mem_we, mem_addr_sel, mem_req, pc_write, (k == 4));
            end
         end
         if (k == 4) begin
            n_tests++;
            if (pc_src !== 2'd0 || reg_we !== 1'b0) begin
               n_fail++;
               $display("FAIL sw_retire: pc_src=%0d reg_we=%b want 0/0", pc_src, reg_we);
            end
            exp_count++;
         end
      end
      n_tests++;
      if (instr_count !== exp_count || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_count: cnt=%0d busy=%b want %0d/0", instr_count, busy, exp_count);
      end
   endtask

   task automatic test_reset_in_mem();
      clear_decoder();
      lw      = 1'b1;
      run     = 1'b1;
      mem_ack = 1'b1;
      repeat (3) next_cycle();
      next_cycle();
      mem_ack = 1'b0;
      @(negedge clk);
      n_tests++;
      if (state !== 3'd4 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mem_pre: state=%0d req=%b want 4/1", state, mem_req);
      end
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      run   = 1'b0;
      exp_count = 0;
      @(negedge clk);
      n_tests++;
      if (state !== 3'd0 || mem_req !== 1'b0 || instr_count !== 32'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mem: state=%0d req=%b cnt=%0d busy=%b want 0/0/0/0", state, mem_req, instr_count, busy);
      end
   endtask

   task automatic test_timeout();
      logic [2:0] es [7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0};
      clear_decoder();
      run     = 1'b1;
      mem_ack = 1'b0;
      for (int k = 0; k < 7; k++) begin
         next_cycle();
         mem_ack = (k == 3);
         if (k == 4) run = 1'b0;
         @(negedge clk);
         n_tests++;
         if (state !== es[k] || err !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack c%0d: state=%0d err=%b want %0d/0", k, state, err, es[k]);
         end
         if (k == 5) exp_count++;
      end
      run     = 1'b1;
      mem_ack = 1'b0;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         if (k >= 5) mem_ack = 1'b1;
         @(negedge clk);
         n_tests++;
         if (k < 4) begin
            if (state !== 3'd1 || mem_req !== 1'b1 || err !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_wait c%0d: state=%0d req=%b err=%b want 1/1/0", k, state, mem_req, err);
            end
         end else begin
            if (state !== 3'd6 || err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 ||
                ir_load !== 1'b0 || pc_write !== 1'b0 || reg_we !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_err c%0d: state=%0d err=%b req=%b busy=%b irl=%b pcw=%b rwe=%b want 6/1/0/0/0/0/0",
                        k, state, err, mem_req, busy, ir_load, pc_write, reg_we);
            end
         end
      end
      n_tests++;
      if (instr_count !== exp_count) begin
         n_fail++;
         $display("FAIL timeout_count: got %0d want %0d", instr_count, exp_count);
      end
      reset = 1'b1;
      run   = 1'b0;
      next_cycle();
      reset = 1'b0;
      exp_count = 0;
      @(negedge clk);
      n_tests++;
      if (state !== 3'd0 || err !== 1'b0 || instr_count !== 32'd0) begin
         n_fail++;
         $display("FAIL timeout_reset: state=%0d err=%b cnt=%0d want 0/0/0", state, err, instr_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_lw_wait();
      test_branch();
      test_jump();
      test_sw_run_drop();
      test_reset_in_mem();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
